// File: rtl/ddr_burst_responder_if.sv
// Burst command bus between a command translator (master) and the DDR responder (slave).
// Write side: wr_en/wr_addr/wr_id/wr_len command, wr_ready pacing, wr_data_en/wr_data beats,
// wr_done completion. Read side: rd_en/rd_addr/rd_id/rd_len command, rd_data/rd_data_valid
// beats, rd_done_p completion. Sticky status: cmd_overflow, proto_err.
interface ddr_burst_responder_if #(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned MEM_DQ_WIDTH    = 16
);
    logic                         wr_en;
    logic [CTRL_ADDR_WIDTH-1:0]   wr_addr;
    logic [3:0]                   wr_id;
    logic [3:0]                   wr_len;
    logic                         wr_ready;
    logic                         wr_data_en;
    logic [MEM_DQ_WIDTH*8-1:0]    wr_data;
    logic                         wr_done;
    logic                         rd_en;
    logic [CTRL_ADDR_WIDTH-1:0]   rd_addr;
    logic [3:0]                   rd_id;
    logic [3:0]                   rd_len;
    logic [MEM_DQ_WIDTH*8-1:0]    rd_data;
    logic                         rd_data_valid;
    logic                         rd_done_p;
    logic                         cmd_overflow;
    logic                         proto_err;

    modport master (
        output wr_en, wr_addr, wr_id, wr_len, wr_data_en, wr_data,
        output rd_en, rd_addr, rd_id, rd_len,
        input  wr_ready, wr_done, rd_data, rd_data_valid, rd_done_p, cmd_overflow, proto_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_id, wr_len, wr_data_en, wr_data,
        input  rd_en, rd_addr, rd_id, rd_len,
        output wr_ready, wr_done, rd_data, rd_data_valid, rd_done_p, cmd_overflow, proto_err
    );
endinterface

// File: rtl/ddr_burst_responder.sv
// DDR controller stand-in: accepts write/read burst commands into one-deep slots, paces
// write data with wr_ready, captures it into a beat RAM, replays reads from the RAM and
// pulses wr_done / rd_done_p when a burst finishes. One burst is in flight at a time.
// Ports: clk (rising edge), rstn (async active-low), bus (slave side of the burst interface).
module ddr_burst_responder #(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned MEM_DQ_WIDTH    = 16,
    parameter int unsigned MEM_AW          = 10
) (
    input logic                  clk,
    input logic                  rstn,
    ddr_burst_responder_if.slave bus
);
    localparam int unsigned DataW = MEM_DQ_WIDTH * 8;
    localparam int unsigned Depth = 1 << MEM_AW;

    typedef enum logic [2:0] {
        StIdle, StWrBeat, StWrDrain, StWrDone, StRdBeat, StRdDrain, StRdDone
    } state_e;

    state_e              state_q, state_d;
    logic                wr_full_q, wr_full_d, rd_full_q, rd_full_d;
    logic [MEM_AW-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [3:0]          wr_len_q, wr_len_d, rd_len_q, rd_len_d;
    logic [MEM_AW-1:0]   base_q, base_d;
    logic [3:0]          len_q, len_d, beat_q, beat_d;
    logic [4:0]          cap_q, cap_d;
    logic [2:0]          tmo_q, tmo_d;
    logic                ovf_q, ovf_d, perr_q, perr_d;
    logic                rd_valid_q;
    logic [DataW-1:0]    rd_data_q;
    logic [DataW-1:0]    mem [Depth];

    logic                take_wr, take_rd, mem_we, rd_issue;
    logic                wr_ready, wr_done, rd_done;
    logic [4:0]          burst_len;
    logic [MEM_AW-1:0]   mem_waddr, mem_raddr;
    logic                unused_bits;

    // Ids and the address bits outside the beat index carry no meaning here.
    assign unused_bits = ^{bus.wr_id, bus.rd_id, bus.wr_addr[2:0], bus.rd_addr[2:0],
                           bus.wr_addr[CTRL_ADDR_WIDTH-1:MEM_AW+3],
                           bus.rd_addr[CTRL_ADDR_WIDTH-1:MEM_AW+3]};

    // Writes take priority over reads when both slots hold a command.
    assign take_wr   = (state_q == StIdle) && wr_full_q;
    assign take_rd   = (state_q == StIdle) && !wr_full_q && rd_full_q;
    assign burst_len = {1'b0, len_q} + 5'd1;
    assign mem_we    = ((state_q == StWrBeat) || (state_q == StWrDrain)) && bus.wr_data_en &&
                       (cap_q != burst_len);
    // Index arithmetic is MEM_AW wide, so bursts wrap around the RAM naturally.
    assign mem_waddr = base_q + MEM_AW'(cap_q);
    assign mem_raddr = base_q + MEM_AW'(beat_q);

    // Command slots: a slot emptied this cycle may be refilled by a same-cycle pulse.
    always_comb begin
        wr_full_d = wr_full_q;
        wr_idx_d  = wr_idx_q;
        wr_len_d  = wr_len_q;
        rd_full_d = rd_full_q;
        rd_idx_d  = rd_idx_q;
        rd_len_d  = rd_len_q;
        ovf_d     = ovf_q;
        if (take_wr) wr_full_d = 1'b0;
        if (take_rd) rd_full_d = 1'b0;
        if (bus.wr_en) begin
            if (!wr_full_q || take_wr) begin
                wr_full_d = 1'b1;
                wr_idx_d  = bus.wr_addr[MEM_AW+2:3];
                wr_len_d  = bus.wr_len;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (bus.rd_en) begin
            if (!rd_full_q || take_rd) begin
                rd_full_d = 1'b1;
                rd_idx_d  = bus.rd_addr[MEM_AW+2:3];
                rd_len_d  = bus.rd_len;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        beat_d   = beat_q;
        cap_d    = mem_we ? cap_q + 5'd1 : cap_q;
        tmo_d    = tmo_q;
        perr_d   = perr_q;
        rd_issue = 1'b0;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        rd_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (take_wr) begin
                    state_d = StWrBeat;
                    base_d  = wr_idx_q;
                    len_d   = wr_len_q;
                    beat_d  = 4'd0;
                    cap_d   = 5'd0;
                    tmo_d   = 3'd0;
                end else if (take_rd) begin
                    state_d = StRdBeat;
                    base_d  = rd_idx_q;
                    len_d   = rd_len_q;
                    beat_d  = 4'd0;
                end
            end
            StWrBeat: begin
                wr_ready = 1'b1;
                if (beat_q == len_q) state_d = StWrDrain;
                else                 beat_d  = beat_q + 4'd1;
            end
            StWrDrain: begin
                // Give up on missing beats after 8 drain cycles so the bus never hangs.
                if (cap_d == burst_len) begin
                    state_d = StWrDone;
                end else if (tmo_q == 3'd7) begin
                    perr_d  = 1'b1;
                    state_d = StWrDone;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            StWrDone: begin
                wr_done = 1'b1;
                state_d = StIdle;
            end
            StRdBeat: begin
                rd_issue = 1'b1;
                if (beat_q == len_q) state_d = StRdDrain;
                else                 beat_d  = beat_q + 4'd1;
            end
            StRdDrain: begin
                // Hold until the final beat has been presented, so done trails data by a gap.
                if (!rd_valid_q) state_d = StRdDone;
            end
            StRdDone: begin
                rd_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            wr_full_q  <= 1'b0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            rd_full_q  <= 1'b0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            cap_q      <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_full_q  <= wr_full_d;
            wr_idx_q   <= wr_idx_d;
            wr_len_q   <= wr_len_d;
            rd_full_q  <= rd_full_d;
            rd_idx_q   <= rd_idx_d;
            rd_len_q   <= rd_len_d;
            base_q     <= base_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            cap_q      <= cap_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            rd_valid_q <= rd_issue;
            if (rd_issue) rd_data_q <= mem[mem_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= bus.wr_data;
    end

    assign bus.wr_ready      = wr_ready;
    assign bus.wr_done       = wr_done;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.rd_done_p     = rd_done;
    assign bus.cmd_overflow  = ovf_q;
    assign bus.proto_err     = perr_q;
endmodule

// File: tb/tb_ddr_burst_responder.sv
// Directed bench for ddr_burst_responder. Cycle t is the value seen just before rising edge t;
// a command driven in step t is sampled at edge t.
module tb_ddr_burst_responder;
    localparam int unsigned AW  = 28;
    localparam int unsigned DQ  = 16;
    localparam int unsigned MAW = 10;
    localparam int unsigned DW  = DQ * 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int t = 0;

    bit          prev_rdy;
    int          sent, allow;
    logic [DW-1:0] data_base;
    int rdy_cnt, rdy_first, rdy_last, wd_cnt, wd_t, rv_cnt, rv_first, rv_last;
    int rdd_cnt, rdd_t, pe_first;
    logic [DW-1:0] rd_q[$];

    always #5 clk = ~clk;

    ddr_burst_responder_if #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) bus ();

    ddr_burst_responder #(
        .CTRL_ADDR_WIDTH(AW),
        .MEM_DQ_WIDTH   (DQ),
        .MEM_AW         (MAW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic clear_mon();
        rdy_cnt = 0; rdy_first = -1; rdy_last = -1; wd_cnt = 0; wd_t = -1;
        rv_cnt = 0; rv_first = -1; rv_last = -1; rdd_cnt = 0; rdd_t = -1; pe_first = -1;
        rd_q.delete();
    endtask

    task automatic arm_data(input logic [DW-1:0] base, input int n);
        data_base = base; allow = n; sent = 0;
    endtask

    // One cycle: drop command pulses, answer last cycle's wr_ready with a data beat, record.
    task automatic step();
        @(negedge clk);
        t++;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.wr_data_en = 1'b0;
        if (prev_rdy && sent < allow) begin
            bus.wr_data_en = 1'b1;
            bus.wr_data    = data_base + DW'(sent);
            sent++;
        end
        prev_rdy = bus.wr_ready;
        if (bus.wr_ready) begin
            if (rdy_cnt == 0) rdy_first = t;
            rdy_last = t; rdy_cnt++;
        end
        if (bus.wr_done) begin wd_cnt++; wd_t = t; end
        if (bus.rd_data_valid) begin
            if (rv_cnt == 0) rv_first = t;
            rv_last = t; rv_cnt++;
            rd_q.push_back(bus.rd_data);
        end
        if (bus.rd_done_p) begin rdd_cnt++; rdd_t = t; end
        if (bus.proto_err && pe_first < 0) pe_first = t;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cmd(input bit w, input logic [AW-1:0] wa, input logic [3:0] wl,
                       input bit r, input logic [AW-1:0] ra, input logic [3:0] rl,
                       output int n);
        step();
        bus.wr_en = w; bus.wr_addr = wa; bus.wr_len = wl; bus.wr_id = 4'h5;
        bus.rd_en = r; bus.rd_addr = ra; bus.rd_len = rl; bus.rd_id = 4'ha;
        n = t;
    endtask

    task automatic check_quiet(input string tag);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++;
            $display("FAIL %s wr_ready got %b want 0", tag, bus.wr_ready); end
        checks++; if (bus.wr_done !== 1'b0) begin errors++;
            $display("FAIL %s wr_done got %b want 0", tag, bus.wr_done); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++;
            $display("FAIL %s rd_data_valid got %b want 0", tag, bus.rd_data_valid); end
        checks++; if (bus.rd_done_p !== 1'b0) begin errors++;
            $display("FAIL %s rd_done_p got %b want 0", tag, bus.rd_done_p); end
        checks++; if (bus.cmd_overflow !== 1'b0) begin errors++;
            $display("FAIL %s cmd_overflow got %b want 0", tag, bus.cmd_overflow); end
        checks++; if (bus.proto_err !== 1'b0) begin errors++;
            $display("FAIL %s proto_err got %b want 0", tag, bus.proto_err); end
        checks++; if (bus.rd_data !== '0) begin errors++;
            $display("FAIL %s rd_data got %h want 0", tag, bus.rd_data); end
    endtask

    task automatic test_reset();
        run(3);
        check_quiet("reset");
        rstn = 1'b1;
        run(3);
    endtask

    task automatic test_write_read_full();
        int n, m;
        clear_mon(); arm_data('0, 16);
        cmd(1'b1, 28'h0, 4'd15, 1'b0, 28'h0, 4'd0, n);
        run(22);
        checks++; if (rdy_cnt !== 16) begin errors++;
            $display("FAIL full_wr_ready_count got %0d want 16", rdy_cnt); end
        checks++; if (rdy_first !== n + 2 || rdy_last !== n + 17) begin errors++;
            $display("FAIL full_wr_ready_window got %0d..%0d want %0d..%0d",
                     rdy_first - n, rdy_last - n, 2, 17); end
        checks++; if (wd_cnt !== 1 || wd_t !== n + 19) begin errors++;
            $display("FAIL full_wr_done got cnt %0d at +%0d want 1 at +19", wd_cnt, wd_t - n); end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h0, 4'd15, m);
        run(24);
        checks++; if (rv_cnt !== 16 || rv_first !== m + 3 || rv_last !== m + 18) begin errors++;
            $display("FAIL full_rd_valid got %0d beats +%0d..+%0d want 16 +3..+18",
                     rv_cnt, rv_first - m, rv_last - m); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_q[i] !== DW'(i)) begin errors++;
                $display("FAIL full_rd_data[%0d] got %h want %h", i, rd_q[i], DW'(i)); end
        end
        checks++; if (rdd_cnt !== 1 || rdd_t !== m + 20) begin errors++;
            $display("FAIL full_rd_done got cnt %0d at +%0d want 1 at +20", rdd_cnt, rdd_t - m); end
    endtask

    task automatic test_offset();
        int n, m;
        clear_mon(); arm_data(128'ha0, 4);
        cmd(1'b1, 28'h80, 4'd3, 1'b0, 28'h0, 4'd0, n);
        run(10);
        checks++; if (wd_cnt !== 1 || wd_t !== n + 7) begin errors++;
            $display("FAIL offset_wr_done got cnt %0d at +%0d want 1 at +7", wd_cnt, wd_t - n); end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h98, 4'd0, m);
        run(8);
        checks++; if (rv_cnt !== 1 || rd_q[0] !== 128'ha3) begin errors++;
            $display("FAIL offset_rd_beat got %0d beats data %h want 1 beats data a3",
                     rv_cnt, rd_q[0]); end
        checks++; if (rdd_t !== m + 5) begin errors++;
            $display("FAIL offset_rd_done got +%0d want +5", rdd_t - m); end
    endtask

    task automatic test_simultaneous();
        int n;
        clear_mon(); arm_data(128'hb0, 2);
        cmd(1'b1, 28'h100, 4'd1, 1'b1, 28'h100, 4'd1, n);
        run(16);
        checks++; if (wd_cnt !== 1 || wd_t !== n + 5) begin errors++;
            $display("FAIL simul_wr_done got cnt %0d at +%0d want 1 at +5", wd_cnt, wd_t - n); end
        checks++; if (rv_first !== n + 8 || rv_last !== n + 9) begin errors++;
            $display("FAIL simul_rd_valid got +%0d..+%0d want +8..+9", rv_first - n, rv_last - n);
        end
        checks++; if (rd_q[0] !== 128'hb0 || rd_q[1] !== 128'hb1) begin errors++;
            $display("FAIL simul_rd_data got %h %h want b0 b1", rd_q[0], rd_q[1]); end
        checks++; if (rdd_cnt !== 1 || rdd_t !== n + 11) begin errors++;
            $display("FAIL simul_rd_done got cnt %0d at +%0d want 1 at +11", rdd_cnt, rdd_t - n);
        end
        checks++; if (bus.cmd_overflow !== 1'b0) begin errors++;
            $display("FAIL simul_overflow got %b want 0", bus.cmd_overflow); end
    endtask

    task automatic test_overflow();
        int n;
        clear_mon(); arm_data(128'he0, 100);
        cmd(1'b1, 28'h200, 4'd0, 1'b0, 28'h0, 4'd0, n);
        step(); bus.wr_en = 1'b1;
        step(); bus.wr_en = 1'b1;
        run(20);
        checks++; if (wd_cnt !== 2 || wd_t !== n + 8) begin errors++;
            $display("FAIL ovf_wr_done got cnt %0d last +%0d want 2 last +8", wd_cnt, wd_t - n); end
        checks++; if (rdy_cnt !== 2) begin errors++;
            $display("FAIL ovf_wr_ready_count got %0d want 2", rdy_cnt); end
        checks++; if (bus.cmd_overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_flag got %b want 1", bus.cmd_overflow); end
    endtask

    task automatic test_proto_err();
        int n, m;
        clear_mon(); arm_data(128'hc0, 6);
        cmd(1'b1, 28'h400, 4'd7, 1'b0, 28'h0, 4'd0, n);
        run(24);
        checks++; if (pe_first !== n + 18) begin errors++;
            $display("FAIL perr_time got +%0d want +18", pe_first - n); end
        checks++; if (wd_cnt !== 1 || wd_t !== n + 18) begin errors++;
            $display("FAIL perr_wr_done got cnt %0d at +%0d want 1 at +18", wd_cnt, wd_t - n); end
        checks++; if (bus.cmd_overflow !== 1'b1) begin errors++;
            $display("FAIL perr_ovf_sticky got %b want 1", bus.cmd_overflow); end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h400, 4'd5, m);
        run(14);
        checks++; if (rv_cnt !== 6 || rdd_cnt !== 1 || rdd_t !== m + 10) begin errors++;
            $display("FAIL perr_rd got %0d beats done cnt %0d at +%0d want 6 1 +10",
                     rv_cnt, rdd_cnt, rdd_t - m); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (rd_q[i] !== 128'hc0 + DW'(i)) begin errors++;
                $display("FAIL perr_rd_data[%0d] got %h want %h", i, rd_q[i], 128'hc0 + DW'(i));
            end
        end
    endtask

    task automatic test_wrap_reset();
        int n, m;
        clear_mon(); arm_data(128'hd0, 4);
        cmd(1'b1, 28'h1ff0, 4'd3, 1'b0, 28'h0, 4'd0, n);
        run(10);
        checks++; if (wd_cnt !== 1 || wd_t !== n + 7) begin errors++;
            $display("FAIL wrap_wr_done got cnt %0d at +%0d want 1 at +7", wd_cnt, wd_t - n); end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h1ff0, 4'd15, m);
        run(5);
        rstn = 1'b0;
        step();
        check_quiet("midreset");
        run(2);
        rstn = 1'b1;
        run(30);
        checks++; if (rdd_cnt !== 0) begin errors++;
            $display("FAIL abandon_rd_done got %0d pulses want 0", rdd_cnt); end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h1ff0, 4'd3, m);
        run(10);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_q[i] !== 128'hd0 + DW'(i)) begin errors++;
                $display("FAIL wrap_rd_data[%0d] got %h want %h", i, rd_q[i], 128'hd0 + DW'(i));
            end
        end
        clear_mon();
        cmd(1'b0, 28'h0, 4'd0, 1'b1, 28'h0, 4'd1, m);
        run(8);
        checks++; if (rd_q[0] !== 128'hd2 || rd_q[1] !== 128'hd3) begin errors++;
            $display("FAIL wrap_low_data got %h %h want d2 d3", rd_q[0], rd_q[1]); end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_id = '0; bus.wr_len = '0;
        bus.wr_data_en = 1'b0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_id = '0; bus.rd_len = '0;
        prev_rdy = 1'b0;
        arm_data('0, 0);
        clear_mon();
        test_reset();
        test_write_read_full();
        test_offset();
        test_simultaneous();
        test_overflow();
        test_proto_err();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
